aer_event_decoder: RTL and testbench
====================================

Name: aer_event_decoder

Overview:
- AER link receiver: accepts address events over a bundled-data 4-phase req/ack handshake and converts each into a one-cycle spike pulse on a per-channel line.
- Output lines feed the SNN core spike inputs (one line per input pixel), replacing local rate encoding with an off-chip event source.
- Buffers events in a small FIFO so the link never drops events; applies backpressure by withholding ack when the FIFO is full.

Parameters:
- NUM_CH, 4, number of spike output channels.
- ADDR_W, 3, AER address width; addresses >= NUM_CH are invalid.
- FIFO_DEPTH, 4, event buffer depth (power of 2, >= 2).
- SYNC_STAGES, 2, synchronizer flops on aer_req (>= 2).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- aer_req  in  1  asynchronous request from sender.
- aer_addr  in  ADDR_W  event address; stable from req rise until ack rise (bundled data).
- aer_ack  out  1  handshake acknowledge, registered.
- enable  in  1  1 = drain FIFO to spike outputs; 0 = hold events.
- spike_out  out  NUM_CH  one-hot, one-cycle spike pulses, registered.
- event_count  out  16  saturating count of delivered spikes.
- addr_err  out  1  one-cycle pulse when an invalid address is accepted.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, active-high): aer_ack=0, spike_out=0, event_count=0, addr_err=0, fifo_level=0, FSM=IDLE, synchronizer cleared.
- aer_req passes through SYNC_STAGES flops to give req_s; aer_addr is sampled only when req_s=1 (it is stable by then).
- FSM states:
  - IDLE: if req_s=1 and FIFO not full: at that edge push aer_addr (if valid), set aer_ack<=1, go to ACK. If req_s=1 and FIFO full: stay in IDLE with ack=0 (backpressure).
  - ACK: hold aer_ack=1 until req_s=0; at that edge set aer_ack<=0 and go to IDLE.
- Full check uses occupancy before the edge; a pop in the same cycle does not free space for that push.
- Latency: req rise to ack rise is SYNC_STAGES+1 edges, within ±1 cycle for async sampling.
- Invalid address (>= NUM_CH): acknowledged normally, not pushed, addr_err=1 for one cycle at the accept edge.
- Drain: at each edge, if enable=1 and FIFO not empty: pop the head and set spike_out <= one-hot(head). Otherwise spike_out <= 0.
  - At most one spike per cycle; FIFO order is preserved.
  - A push into an empty FIFO at edge E produces its spike in the cycle after edge E+1.
- Simultaneous push and pop are allowed: fifo_level is unchanged and both take effect.
- enable=0: FIFO holds its contents and handshakes continue until full.
- event_count: +1 per emitted spike, saturates at 16'hFFFF.
- Reset mid-handshake: ack drops immediately and the FIFO is flushed. The sender must restart its 4-phase cycle.
  - If req is still high after reset releases, it is treated as a new event.

Decomposition:
- Package snn_aer_pkg holds:
  - FSM state encoding (IDLE, ACK).
  - Default widths.
  - Function that builds a one-hot vector from an address.
  - Function for log2 ceiling.
- Sub-module aer_event_fifo: synchronous FIFO with push/pop/full/empty/level, async active-high reset, no write when full, no read when empty.
- Synchronizer is inline flops.

Test Plan:
- Single event, addr=2, enable=1: ack rises 3±1 cycles after req. After req drops, ack falls. spike_out=4'b0100 for exactly one cycle. event_count=1, fifo_level returns to 0.
- enable=0, send events 0,1,2,3,0:
  - First 4 acked, fifo_level=4, 5th req left un-acked.
  - Set enable=1: spikes 0001,0010,0100,1000 on consecutive cycles, then 5th acked, then 0001.
  - event_count=5.
- Invalid addr=5: acked normally, addr_err pulses once, no spike_out activity, event_count unchanged, fifo_level stays 0.
- Assert rst while ack=1 with 2 events queued: ack=0, spike_out=0, fifo_level=0 immediately. Release with req high: new event accepted and delivered once.
- Pattern stream 0,2,3 repeated 100 times via back-to-back handshakes, enable=1: 300 spikes in order, per-channel counts 100/0/100/100, event_count=300, no addr_err.

Source files
------------

// File: rtl/snn_aer_pkg.sv
// Shared definitions for the AER event decoder: FSM encoding, default widths,
// and small helpers (one-hot builder, ceiling log2).
package snn_aer_pkg;

    // Handshake FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    // Default parameter values
    localparam int unsigned DEF_NUM_CH      = 4;
    localparam int unsigned DEF_ADDR_W      = 3;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Widest spike vector the one-hot helper can build
    localparam int unsigned MAX_CH = 64;

    // Ceiling log2, with clog2_u(1) = 0
    function automatic int unsigned clog2_u(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // One-hot vector with bit idx set; callers truncate to their channel count
    function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx);
        return MAX_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// Synchronous event FIFO.
// Ports: clk, rst (async, active-high), push/wdata, pop/rdata (head, valid
// when not empty), full, empty, level (occupancy). Push when full and pop when
// empty are ignored.
module aer_event_fifo
    import snn_aer_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned WIDTH = DEF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      pop,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic [clog2_u(DEPTH):0]   level
);

    localparam int unsigned PTR_W = clog2_u(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/aer_event_decoder.sv
// AER link receiver: 4-phase req/ack bundled-data handshake in, one-cycle
// one-hot spike pulses out, with an event FIFO for backpressure.
// Ports: clk, rst (async, active-high), aer_req/aer_addr/aer_ack (link),
// enable (drain FIFO), spike_out (one-hot pulse), event_count (saturating
// spike count), addr_err (invalid address pulse), fifo_level (occupancy).
module aer_event_decoder
    import snn_aer_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            aer_req,
    input  logic [ADDR_W-1:0]               aer_addr,
    output logic                            aer_ack,
    input  logic                            enable,
    output logic [NUM_CH-1:0]               spike_out,
    output logic [15:0]                     event_count,
    output logic                            addr_err,
    output logic [clog2_u(FIFO_DEPTH):0]    fifo_level
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [0:0]             state_q;
    logic [0:0]             state_d;
    logic                   ack_d;
    logic                   err_d;
    logic                   push;
    logic                   pop;
    logic                   addr_valid;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ADDR_W-1:0]      head;

    // Request synchronizer; aer_addr is only looked at once req_s is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], aer_req};
    end
    assign req_s = sync_q[SYNC_STAGES-1];

    assign addr_valid = (32'(aer_addr) < NUM_CH);
    assign pop        = enable && !fifo_empty;

    // FSM state and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            aer_ack  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            aer_ack  <= ack_d;
            addr_err <= err_d;
        end
    end

    // Accept when not full (occupancy before this edge); invalid addresses
    // are acknowledged but dropped
    always_comb begin
        state_d = state_q;
        ack_d   = aer_ack;
        err_d   = 1'b0;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ack_d = 1'b0;
                if (req_s && !fifo_full) begin
                    push    = addr_valid;
                    err_d   = !addr_valid;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                ack_d = 1'b1;
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    aer_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (aer_addr),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Drain one event per cycle into a one-hot pulse and count it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_out   <= '0;
            event_count <= '0;
        end else begin
            spike_out <= pop ? NUM_CH'(onehot(32'(head))) : '0;
            if (pop && event_count != 16'hFFFF) begin
                event_count <= event_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_aer_event_decoder.sv
// Self-checking bench for aer_event_decoder: scoreboard of expected channel
// numbers, filled when an event is offered and drained by the spike monitor.
module tb_aer_event_decoder;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned ADDR_W = 3;

    logic              clk;
    logic              rst;
    logic              aer_req;
    logic [ADDR_W-1:0] aer_addr;
    logic              aer_ack;
    logic              enable;
    logic [NUM_CH-1:0] spike_out;
    logic [15:0]       event_count;
    logic              addr_err;
    logic [2:0]        fifo_level;

    int checks;
    int failures;
    int exp_q[$];
    int spike_total;
    int err_total;
    int ch_cnt [NUM_CH];

    aer_event_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .aer_req     (aer_req),
        .aer_addr    (aer_addr),
        .aer_ack     (aer_ack),
        .enable      (enable),
        .spike_out   (spike_out),
        .event_count (event_count),
        .addr_err    (addr_err),
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Spike monitor: every pulse must be one-hot and match the scoreboard head
    always @(negedge clk) begin
        if (!rst) begin
            if (addr_err) err_total = err_total + 1;
            if (spike_out != '0) begin
                spike_total = spike_total + 1;
                if (exp_q.size() == 0) begin
                    check_eq("spike_unexpected", 32'(spike_out), 32'd0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check_eq("spike_order", 32'(spike_out), 32'd1 << e);
                    ch_cnt[e] = ch_cnt[e] + 1;
                end
            end
        end
    end

    task automatic wait_ack(input logic val, input string tag, output int cycles);
        cycles = 0;
        while (aer_ack !== val && cycles < 50) begin
            @(negedge clk);
            cycles = cycles + 1;
        end
        if (aer_ack !== val) check_eq(tag, 32'(aer_ack), 32'(val));
    endtask

    task automatic raise_req(input int addr);
        #1;
        aer_addr = ADDR_W'(addr);
        aer_req  = 1'b1;
        if (addr < NUM_CH) exp_q.push_back(addr);
    endtask

    task automatic send_event(input int addr);
        int cyc;
        raise_req(addr);
        wait_ack(1'b1, "ack_rise_timeout", cyc);
        #1 aer_req = 1'b0;
        wait_ack(1'b0, "ack_fall_timeout", cyc);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        aer_req = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cyc;
        int s0;
        int e0;
        int c0 [NUM_CH];
        logic [3:0] seq [4];
        checks = 0; failures = 0; spike_total = 0; err_total = 0;
        for (int i = 0; i < NUM_CH; i++) ch_cnt[i] = 0;
        rst = 1'b1; aer_req = 1'b0; aer_addr = '0; enable = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ack", 32'(aer_ack), 32'd0);
        check_eq("rst_spike", 32'(spike_out), 32'd0);
        check_eq("rst_count", 32'(event_count), 32'd0);
        check_eq("rst_err", 32'(addr_err), 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single event to channel 2 with latency measurement
        enable = 1'b1;
        raise_req(2);
        wait_ack(1'b1, "t1_ack_timeout", cyc);
        check_eq("t1_latency_ok", 32'(cyc >= 2 && cyc <= 4), 32'd1);
        #1 aer_req = 1'b0;
        wait_ack(1'b0, "t1_ack_fall_timeout", cyc);
        wait_drain();
        check_eq("t1_count", 32'(event_count), 32'd1);
        check_eq("t1_level", 32'(fifo_level), 32'd0);
        check_eq("t1_ch2", 32'(ch_cnt[2]), 32'd1);

        // Fill with enable low, then backpressure on the fifth event
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) send_event(i);
        check_eq("t2_level_full", 32'(fifo_level), 32'd4);
        raise_req(0);
        repeat (10) @(negedge clk);
        check_eq("t2_backpressure_ack", 32'(aer_ack), 32'd0);
        check_eq("t2_level_hold", 32'(fifo_level), 32'd4);
        enable = 1'b1;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t2_consecutive", 32'(spike_out), 32'(seq[i]));
        end
        wait_ack(1'b1, "t2_fifth_ack_timeout", cyc);
        #1 aer_req = 1'b0;
        wait_ack(1'b0, "t2_fifth_fall_timeout", cyc);
        wait_drain();
        check_eq("t2_count", 32'(event_count), 32'd5);

        // Invalid address: acked, flagged, not delivered
        s0 = spike_total; e0 = err_total; cyc = int'(event_count);
        send_event(5);
        repeat (6) @(negedge clk);
        check_eq("t3_err_pulses", 32'(err_total - e0), 32'd1);
        check_eq("t3_no_spike", 32'(spike_total - s0), 32'd0);
        check_eq("t3_count", 32'(event_count), 32'(cyc));
        check_eq("t3_level", 32'(fifo_level), 32'd0);

        // Reset mid-handshake with two events queued
        enable = 1'b0;
        send_event(3);
        raise_req(1);
        wait_ack(1'b1, "t4_ack_timeout", cyc);
        check_eq("t4_level_pre", 32'(fifo_level), 32'd2);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check_eq("t4_rst_ack", 32'(aer_ack), 32'd0);
        check_eq("t4_rst_spike", 32'(spike_out), 32'd0);
        check_eq("t4_rst_level", 32'(fifo_level), 32'd0);
        repeat (2) @(negedge clk);
        s0 = spike_total;
        exp_q.push_back(1);
        enable = 1'b1;
        rst = 1'b0;
        wait_ack(1'b1, "t4_new_ack_timeout", cyc);
        #1 aer_req = 1'b0;
        wait_ack(1'b0, "t4_new_fall_timeout", cyc);
        wait_drain();
        repeat (6) @(negedge clk);
        check_eq("t4_once", 32'(spike_total - s0), 32'd1);
        check_eq("t4_count", 32'(event_count), 32'd1);

        // Streaming pattern 0,2,3 x100
        do_reset();
        enable = 1'b1;
        e0 = err_total;
        for (int i = 0; i < NUM_CH; i++) c0[i] = ch_cnt[i];
        for (int r = 0; r < 100; r++) begin
            send_event(0);
            send_event(2);
            send_event(3);
        end
        wait_drain();
        check_eq("t5_ch0", 32'(ch_cnt[0] - c0[0]), 32'd100);
        check_eq("t5_ch1", 32'(ch_cnt[1] - c0[1]), 32'd0);
        check_eq("t5_ch2", 32'(ch_cnt[2] - c0[2]), 32'd100);
        check_eq("t5_ch3", 32'(ch_cnt[3] - c0[3]), 32'd100);
        check_eq("t5_count", 32'(event_count), 32'd300);
        check_eq("t5_no_err", 32'(err_total - e0), 32'd0);
        check_eq("t5_level", 32'(fifo_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
